// File: rtl/rf_pkg.sv
// Shared defaults and index type for the parametrised register file.
// The defaults match the original 4x16 CPU register file with two read ports.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 2;
  localparam int RF_NRD    = 2;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register mux, optional write bypass,
// optional hard-wired zero register, and the busy flag for the addressed register.
module rf_read_port import rf_pkg::*; #(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] i_regs,
  input  logic [(2**ADDR_W)-1:0]        i_busy,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  input  logic                          i_wr_en,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [DATA_W-1:0]             i_wr_data,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic                          o_rd_busy
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] w_data;
  logic              w_busy;

  // Priority, lowest to highest: stored value, arriving write, zero register.
  always_comb begin
    w_data = '0;
    w_busy = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (i_rd_addr == ADDR_W'(k)) begin
        w_data = i_regs[k*DATA_W +: DATA_W];
        w_busy = i_busy[k];
      end
    end
    if (BYPASS != 0 && i_wr_en && (i_wr_addr == i_rd_addr)) begin
      w_data = i_wr_data;
      w_busy = 1'b0;
    end
    if (ZERO_REG0 != 0 && (i_rd_addr == '0)) begin
      w_data = '0;
      w_busy = 1'b0;
    end
  end

  assign o_rd_data = w_data;
  assign o_rd_busy = w_busy;

endmodule

// File: rtl/rf_param.sv
// Parametrised register file with write-to-read bypass, optional zero register
// and a per-register busy scoreboard for multi-cycle destination reservation.
module rf_param import rf_pkg::*; #(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NRD       = RF_NRD,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int NREG = 2**ADDR_W;

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("rf_param: NRD must be in 1..4");
  end

  logic [NREG*DATA_W-1:0] r_regs;
  logic [NREG-1:0]        r_busy;
  logic                   w_wr_ok;
  logic                   w_claim_ok;

  assign w_wr_ok    = wr_en    && !(ZERO_REG0 != 0 && wr_addr == '0);
  assign w_claim_ok = claim_en && !(ZERO_REG0 != 0 && claim_addr == '0);

  // Claim is evaluated after the write so a same-address claim (newer
  // instruction) leaves the register busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (w_wr_ok && (wr_addr == ADDR_W'(k))) begin
          r_regs[k*DATA_W +: DATA_W] <= wr_data;
          r_busy[k]                  <= 1'b0;
        end
        if (w_claim_ok && (claim_addr == ADDR_W'(k))) begin
          r_busy[k] <= 1'b1;
        end
      end
    end
  end

  assign busy_vec = r_busy;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG0(ZERO_REG0)
    ) u_port (
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_rd_addr(rd_addr[g*ADDR_W +: ADDR_W]),
      .i_wr_en  (wr_en),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .o_rd_data(rd_data[g*DATA_W +: DATA_W]),
      .o_rd_busy(rd_busy[g])
    );
  end

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: default config driven from a vector table,
// plus short sequences on BYPASS=0 and ZERO_REG0=1 instances sharing the stimulus.
module tb_rf_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        claim_en;
  logic [1:0]  claim_addr;

  logic [31:0] m_rd_data, n_rd_data, z_rd_data;
  logic [1:0]  m_rd_busy, n_rd_busy, z_rd_busy;
  logic [3:0]  m_busy_vec, n_busy_vec, z_busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_param #(.BYPASS(1), .ZERO_REG0(0)) u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(m_rd_data), .rd_busy(m_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(m_busy_vec));

  rf_param #(.BYPASS(0), .ZERO_REG0(0)) u_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(n_busy_vec));

  rf_param #(.BYPASS(1), .ZERO_REG0(1)) u_z (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(z_busy_vec));

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        ce;
    logic [1:0]  ca;
    logic [1:0]  a0;
    logic [1:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        b0;
    logic        b1;
    logic [3:0]  bv;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic drive(input logic rst, input logic we, input logic [1:0] wa, input logic [15:0] wd,
                       input logic ce, input logic [1:0] ca, input logic [1:0] a0, input logic [1:0] a1);
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca; rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; rd_addr = '0;

    //           rst we wa wd        ce ca a0 a1 d0        d1        b0 b1 bv
    tbl[0]  = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd1,2'd3,16'h0000,16'h0000,1'b0,1'b0,4'b0000};
    tbl[1]  = '{1'b0,1'b1,2'd1,16'h1234,1'b0,2'd0,2'd1,2'd3,16'h1234,16'h0000,1'b0,1'b0,4'b0000};
    tbl[2]  = '{1'b0,1'b1,2'd3,16'hABCD,1'b0,2'd0,2'd1,2'd3,16'h1234,16'hABCD,1'b0,1'b0,4'b0000};
    tbl[3]  = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd1,2'd3,16'h1234,16'hABCD,1'b0,1'b0,4'b0000};
    tbl[4]  = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd0,2'd2,16'h0000,16'h0000,1'b0,1'b0,4'b0000};
    tbl[5]  = '{1'b0,1'b1,2'd2,16'h5A5A,1'b0,2'd0,2'd2,2'd2,16'h5A5A,16'h5A5A,1'b0,1'b0,4'b0000};
    tbl[6]  = '{1'b0,1'b0,2'd0,16'h0000,1'b1,2'd1,2'd1,2'd2,16'h1234,16'h5A5A,1'b0,1'b0,4'b0000};
    tbl[7]  = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd1,2'd1,16'h1234,16'h1234,1'b1,1'b1,4'b0010};
    tbl[8]  = '{1'b0,1'b1,2'd1,16'h0007,1'b0,2'd0,2'd1,2'd3,16'h0007,16'hABCD,1'b0,1'b0,4'b0010};
    tbl[9]  = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd1,2'd0,16'h0007,16'h0000,1'b0,1'b0,4'b0000};
    tbl[10] = '{1'b0,1'b1,2'd3,16'h00FF,1'b1,2'd3,2'd3,2'd1,16'h00FF,16'h0007,1'b0,1'b0,4'b0000};
    tbl[11] = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd3,2'd3,16'h00FF,16'h00FF,1'b1,1'b1,4'b1000};
    tbl[12] = '{1'b0,1'b1,2'd2,16'h1111,1'b1,2'd3,2'd2,2'd3,16'h1111,16'h00FF,1'b0,1'b1,4'b1000};
    tbl[13] = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd2,2'd3,16'h1111,16'h00FF,1'b0,1'b1,4'b1000};
    tbl[14] = '{1'b0,1'b1,2'd1,16'h1111,1'b1,2'd2,2'd2,2'd1,16'h1111,16'h1111,1'b0,1'b0,4'b1000};
    tbl[15] = '{1'b1,1'b1,2'd1,16'h2222,1'b0,2'd0,2'd3,2'd2,16'h00FF,16'h1111,1'b1,1'b1,4'b1100};
    tbl[16] = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd1,2'd3,16'h0000,16'h0000,1'b0,1'b0,4'b0000};
    tbl[17] = '{1'b0,1'b0,2'd0,16'h0000,1'b0,2'd0,2'd2,2'd0,16'h0000,16'h0000,1'b0,1'b0,4'b0000};

    // Initial reset: one rising edge with reset high.
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ce, tbl[i].ca, tbl[i].a0, tbl[i].a1);
      chk($sformatf("row%0d rd_data0", i), 32'(m_rd_data[15:0]),  32'(tbl[i].d0));
      chk($sformatf("row%0d rd_data1", i), 32'(m_rd_data[31:16]), 32'(tbl[i].d1));
      chk($sformatf("row%0d rd_busy0", i), 32'(m_rd_busy[0]),     32'(tbl[i].b0));
      chk($sformatf("row%0d rd_busy1", i), 32'(m_rd_busy[1]),     32'(tbl[i].b1));
      chk($sformatf("row%0d busy_vec", i), 32'(m_busy_vec),       32'(tbl[i].bv));
    end

    // BYPASS=0: old value until the edge after the write; busy not cleared early.
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd0);
    drive(1'b0, 1'b1, 2'd2, 16'h5A5A, 1'b0, 2'd0, 2'd2, 2'd0);
    chk("nb same-cycle r2", 32'(n_rd_data[15:0]), 32'h0000);
    chk("byp same-cycle r2", 32'(m_rd_data[15:0]), 32'h5A5A);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd2, 2'd0);
    chk("nb next-cycle r2", 32'(n_rd_data[15:0]), 32'h5A5A);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd1, 2'd0);
    drive(1'b0, 1'b1, 2'd1, 16'h0007, 1'b0, 2'd0, 2'd1, 2'd0);
    chk("nb busy during write", 32'(n_rd_busy[0]), 32'd1);
    chk("nb data during write", 32'(n_rd_data[15:0]), 32'h0000);
    chk("byp busy during write", 32'(m_rd_busy[0]), 32'd0);
    chk("byp data during write", 32'(m_rd_data[15:0]), 32'h0007);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd1, 2'd0);
    chk("nb busy_vec after write", 32'(n_busy_vec), 32'h0);
    chk("nb r1 after write", 32'(n_rd_data[15:0]), 32'h0007);

    // ZERO_REG0=1: write and claim to r0 have no effect.
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd0);
    drive(1'b0, 1'b1, 2'd0, 16'hFFFF, 1'b1, 2'd0, 2'd0, 2'd0);
    chk("zero r0 same-cycle data", 32'(z_rd_data[15:0]), 32'h0000);
    chk("zero r0 same-cycle busy", 32'(z_rd_busy[0]), 32'd0);
    chk("nozero r0 bypass", 32'(m_rd_data[15:0]), 32'hFFFF);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd0);
    chk("zero r0 data", 32'(z_rd_data[31:16]), 32'h0000);
    chk("zero r0 busy", 32'(z_rd_busy[1]), 32'd0);
    chk("zero busy_vec", 32'(z_busy_vec), 32'h0);
    chk("nozero r0 data", 32'(m_rd_data[15:0]), 32'hFFFF);
    chk("nozero r0 busy", 32'(m_rd_busy[0]), 32'd1);
    chk("nozero busy_vec", 32'(m_busy_vec), 32'h1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
